// File: rtl/register_file_write_stage.sv
// register_file_write_stage
//   Storage stage of the RV32I register file. Write-back requests enter an
//   in-order write queue through a valid/ready handshake, and one queued write
//   per cycle is committed into x1..x31. Committed state is exported as a flat
//   bus for the downstream 32:1 read muxes. A pending-write mask is provided
//   for hazard checks. x0 is hardwired to zero.
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : synchronous, active-high; flushes the queue, loads reset values
//   Write_Valid    : write-back request present
//   Write_Ready    : queue can accept a request this cycle (combinational)
//   Write_Register : destination register index
//   Write_Data     : value to write
//   Registers_Flat : committed registers, register k = [k*N +: N]
//   Pending_Mask   : bit k set while a write to xk is queued
//   Queue_Empty    : no queued writes
// DEPTH must be 2 or 4; the pointers rely on a power-of-two depth to wrap.

module register_file_cell #(
   parameter int               N         = 32,
   parameter logic [N-1:0]     RESET_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset)   q <= RESET_VAL;
      else if (we) q <= d;
   end
endmodule

module register_file_write_stage #(
   parameter int           N        = 32,
   parameter int           DEPTH    = 2,
   parameter logic [N-1:0] SP_RESET = 32'h7FFF_EFFC,
   parameter logic [N-1:0] GP_RESET = 32'h1000_8000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Write_Valid,
   output logic            Write_Ready,
   input  logic [4:0]      Write_Register,
   input  logic [N-1:0]    Write_Data,
   output logic [32*N-1:0] Registers_Flat,
   output logic [31:0]     Pending_Mask,
   output logic            Queue_Empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef struct packed {
      logic [4:0]   rd;
      logic [N-1:0] data;
   } wr_entry_t;

   wr_entry_t        entry_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [PW-1:0]    head_q, tail_q;
   logic [CW-1:0]    count_q;

   logic      xfer, enq, commit;
   wr_entry_t head_e;

   assign Write_Ready = ~reset & (count_q < DEPTH_C);
   assign xfer        = Write_Valid & Write_Ready;
   // writes to x0 complete the handshake but are dropped here
   assign enq         = xfer & (Write_Register != 5'd0);
   assign commit      = (count_q != '0);
   assign head_e      = entry_q[head_q];
   assign Queue_Empty = (count_q == '0);

   // Enqueue and commit never target the same slot: enqueue needs
   // count < DEPTH and commit needs count > 0, so tail != head when both fire.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         if (enq) begin
            entry_q[tail_q] <= '{rd: Write_Register, data: Write_Data};
            vld_q[tail_q]   <= 1'b1;
            tail_q          <= tail_q + 1'b1;
         end
         if (commit) begin
            vld_q[head_q] <= 1'b0;
            head_q        <= head_q + 1'b1;
         end
         count_q <= count_q + CW'(enq) - CW'(commit);
      end
   end

   always_comb begin
      Pending_Mask = '0;
      for (int i = 0; i < DEPTH; i++)
         if (vld_q[i]) Pending_Mask[entry_q[i].rd] = 1'b1;
      Pending_Mask[0] = 1'b0;
   end

   logic [31:0][N-1:0] regs;
   assign regs[0] = '0;

   for (genvar k = 1; k < 32; k++) begin : g_reg
      localparam logic [N-1:0] RV = (k == 2) ? SP_RESET :
                                    (k == 3) ? GP_RESET : '0;
      register_file_cell #(.N(N), .RESET_VAL(RV)) u_cell (
         .clk   (clk),
         .reset (reset),
         .we    (commit && (head_e.rd == 5'(k))),
         .d     (head_e.data),
         .q     (regs[k])
      );
   end

   assign Registers_Flat = regs;
endmodule

// File: tb/tb_register_file_write_stage.sv
// Scoreboard bench: the stimulus process pushes expectations tagged with the
// edge count after which they must hold; the monitor pops and compares them
// on the falling edge.
module tb_register_file_write_stage;
   localparam int N = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            Write_Valid;
   logic            Write_Ready;
   logic [4:0]      Write_Register;
   logic [N-1:0]    Write_Data;
   logic [32*N-1:0] Registers_Flat;
   logic [31:0]     Pending_Mask;
   logic            Queue_Empty;

   register_file_write_stage #(.N(N), .DEPTH(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .Write_Valid    (Write_Valid),
      .Write_Ready    (Write_Ready),
      .Write_Register (Write_Register),
      .Write_Data     (Write_Data),
      .Registers_Flat (Registers_Flat),
      .Pending_Mask   (Pending_Mask),
      .Queue_Empty    (Queue_Empty)
   );

   always #5 clk = ~clk;

   typedef enum int {K_REG, K_MASK, K_READY, K_EMPTY} kind_t;
   typedef struct {
      int          cyc;
      kind_t       kind;
      int          idx;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   passed = 0;
   bit   done   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_at(input int dc, input kind_t k, input int idx, input logic [31:0] v);
      exp_t e;
      e.cyc = cyc + dc; e.kind = k; e.idx = idx; e.val = v;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // monitor
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t        e;
         logic [31:0] act;
         e = q.pop_front();
         case (e.kind)
            K_REG:   act = Registers_Flat[e.idx*N +: N];
            K_MASK:  act = Pending_Mask;
            K_READY: act = {31'd0, Write_Ready};
            default: act = {31'd0, Queue_Empty};
         endcase
         checks++;
         if (e.cyc != cyc)
            $display("FAIL stale_%s_%0d cyc=%0d due=%0d", e.kind.name(), e.idx, cyc, e.cyc);
         else if (act !== e.val)
            $display("FAIL %s_%0d cyc=%0d got=%h exp=%h", e.kind.name(), e.idx, cyc, act, e.val);
         else
            passed++;
      end
   end

   initial begin
      reset = 1'b1; Write_Valid = 1'b0; Write_Register = '0; Write_Data = '0;
      step(); step();
      // Write_Ready low while reset is held
      expect_at(0, K_READY, 0, 32'd0);
      step();
      reset = 1'b0;
      // test 1: reset state
      for (int r = 0; r < 32; r++)
         expect_at(0, K_REG, r, (r == 2) ? 32'h7FFF_EFFC : (r == 3) ? 32'h1000_8000 : 32'd0);
      expect_at(0, K_READY, 0, 32'd1);
      expect_at(0, K_EMPTY, 0, 32'd1);
      expect_at(0, K_MASK,  0, 32'd0);
      step();

      // test 2: single write, one-cycle commit latency
      Write_Valid = 1'b1; Write_Register = 5'd5; Write_Data = 32'hDEAD_BEEF;
      expect_at(1, K_MASK,  0, 32'h20);
      expect_at(1, K_REG,   5, 32'd0);
      expect_at(1, K_EMPTY, 0, 32'd0);
      step();
      Write_Valid = 1'b0;
      expect_at(1, K_REG,   5, 32'hDEAD_BEEF);
      expect_at(1, K_MASK,  0, 32'd0);
      expect_at(1, K_EMPTY, 0, 32'd1);
      step();

      // test 3: x0 write accepted and dropped
      Write_Valid = 1'b1; Write_Register = 5'd0; Write_Data = 32'hFFFF_FFFF;
      expect_at(0, K_READY, 0, 32'd1);
      expect_at(1, K_EMPTY, 0, 32'd1);
      expect_at(1, K_MASK,  0, 32'd0);
      expect_at(1, K_REG,   0, 32'd0);
      step();
      Write_Valid = 1'b0;
      expect_at(1, K_REG, 0, 32'd0);
      step();

      // test 4: back-to-back writes to x7
      Write_Valid = 1'b1; Write_Register = 5'd7; Write_Data = 32'd1;
      expect_at(1, K_MASK, 0, 32'h80);
      expect_at(1, K_REG,  7, 32'd0);
      step();
      Write_Data = 32'd2;
      expect_at(1, K_MASK, 0, 32'h80);
      expect_at(1, K_REG,  7, 32'd1);
      step();
      Write_Valid = 1'b0;
      expect_at(1, K_MASK, 0, 32'd0);
      expect_at(1, K_REG,  7, 32'd2);
      step();

      // test 5: streaming distinct targets, one commit per cycle, pointers wrap
      for (int i = 0; i < 8; i++) begin
         Write_Valid = 1'b1; Write_Register = 5'(11 + i); Write_Data = 32'hA000 + i;
         expect_at(0, K_READY, 0, 32'd1);
         expect_at(1, K_MASK, 0, 32'd1 << (11 + i));
         if (i > 0) expect_at(1, K_REG, 10 + i, 32'hA000 + i - 1);
         step();
      end
      Write_Valid = 1'b0;
      expect_at(1, K_REG,  18, 32'hA007);
      expect_at(1, K_MASK, 0,  32'd0);
      step();

      // test 6: reset with a write queued and another offered
      Write_Valid = 1'b1; Write_Register = 5'd9; Write_Data = 32'h9999_9999;
      expect_at(1, K_MASK, 0, 32'h200);
      step();
      reset = 1'b1; Write_Register = 5'd10; Write_Data = 32'hAAAA_AAAA;
      expect_at(0, K_READY, 0, 32'd0);
      expect_at(1, K_REG,   9,  32'd0);
      expect_at(1, K_REG,   10, 32'd0);
      expect_at(1, K_REG,   5,  32'd0);
      expect_at(1, K_REG,   2,  32'h7FFF_EFFC);
      expect_at(1, K_MASK,  0,  32'd0);
      expect_at(1, K_EMPTY, 0,  32'd1);
      step();
      reset = 1'b0; Write_Valid = 1'b0;
      expect_at(1, K_REG,  9,  32'd0);
      expect_at(1, K_REG,  10, 32'd0);
      expect_at(1, K_MASK, 0,  32'd0);
      step();
      step(); step();

      if (q.size() != 0) begin
         checks++;
         $display("FAIL scoreboard_drain left=%0d required=0", q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
